vector_a_stream_reader: RTL and testbench
=========================================

// Module: vector_a_stream_reader
// PURPOSE
//  Read-side companion to the 8-entry vector-A register file. On start it takes the eight
//  parallel entries (a_0..a_7), then streams them out one element per transfer, in index
//  order, over a valid/ready handshake. It sits between the vector-A register file and the
//  downstream MAC/datapath consumer, and reports completion with a one-cycle done pulse.
// PARAMETERS
//  DATA_W    34  width of each vector element; must match the register file entry width
//  SNAPSHOT  1   1: capture all 8 entries at start; 0: read live a_N_data at transfer time
// PORTS
//  clk          in   1       system clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  start        in   1       begin a read sequence; honoured only in IDLE
//  a_0_data..a_7_data in DATA_W each  parallel entries from the register file
//  out_valid    out  1       out_data/out_idx/out_last are valid
//  out_ready    in   1       consumer accepts; transfer = out_valid & out_ready
//  out_data     out  DATA_W  current element
//  out_idx      out  3       index (0..7) of the current element
//  out_last     out  1       current element is the final one of the sequence
//  busy         out  1       high in LOAD, STREAM and DONE
//  done         out  1       one-cycle pulse after the final transfer
// BEHAVIOUR
//  - Reset (async): state=IDLE, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0,
//    done=0, snapshot regs=0, mask=0. Reset mid-sequence aborts it; no done pulse.
//  - FSM: IDLE -start-> LOAD -> STREAM -(final transfer)-> DONE -> IDLE.
//  - IDLE: outputs idle. start=1 at edge: snapshot regs <= a_N_data (SNAPSHOT=1), build
//    8-bit mask, go to LOAD. start outside IDLE is ignored (no queueing).
//  - LOAD (1 cycle): idx <= first set bit of mask. If mask==0 -> DONE, else -> STREAM.
//    Latency: out_valid first high 2 cycles after the start edge.
//  - STREAM: out_valid=1. out_data = element[idx] (snapshot or live per SNAPSHOT).
//    While out_valid & !out_ready, out_data/out_idx/out_last hold stable (SNAPSHOT=1).
//    On transfer: idx <= next set bit above idx; if none (out_last=1) -> DONE with
//    out_valid=0 next cycle. Back-to-back transfers: one element per cycle.
//  - out_last = no set mask bit above idx. Index never wraps; 7 is always terminal.
//  - DONE (1 cycle): done=1, out_valid=0, busy=1; then IDLE. start in DONE ignored.
//  - start held high across sequences: a new sequence starts on the first IDLE cycle.
//  - Writes to the register file during STREAM do not affect output when SNAPSHOT=1.
//  - No arithmetic on data; elements pass through unmodified, full DATA_W.
// CONFIGURATION
//  VEC_A_RD_SKIP_ZERO_EN defined: mask bit N = (a_N_data != 0) at the start edge; zero
//    entries are skipped, out_idx shows the true index, out_last marks the last non-zero
//    entry; all-zero vector -> no out_valid, done pulses 2 cycles after start.
//  Not defined: mask = 8'hFF; all eight entries stream, idx 0..7, out_last at idx 7.
// TESTING
//  1 a_N=N+1, ready=1, start pulse -> valid at +2, data 1..8 on 8 consecutive cycles,
//    out_idx 0..7, out_last only at idx 7, done pulse 1 cycle after last transfer.
//  2 ready toggled 1/0 every cycle -> each element held while ready=0, no element lost or
//    duplicated, 8 transfers total, done once.
//  3 SNAPSHOT=1: overwrite a_3 with 34'h3FFFFFFFF during STREAM -> stream still shows
//    old a_3 value; start pulsed mid-stream -> ignored, exactly 8 transfers.
//  4 rst asserted after 3rd transfer -> all outputs 0 immediately, no done; new start
//    afterwards -> full 8-element sequence from idx 0.
//  5 SKIP_ZERO_EN, a_1=a_4=a_7 nonzero, rest 0 -> 3 transfers, idx 1,4,7, last at 7;
//    all entries 0 -> out_valid never high, done at start+2.
//  6 Macro off, all entries 0 -> 8 transfers of 34'h0, idx 0..7, done pulse.

Source files
------------

// File: rtl/vector_a_stream_reader_if.sv
// Handshake/bus bundle between the vector-A register file, the stream reader and its consumer.
// master = the reader (drives the out_* stream), slave = the register file / consumer side.
interface vector_a_stream_reader_if #(
    parameter int DATA_W = 34
);
    logic              start;
    logic [DATA_W-1:0] a_0_data;
    logic [DATA_W-1:0] a_1_data;
    logic [DATA_W-1:0] a_2_data;
    logic [DATA_W-1:0] a_3_data;
    logic [DATA_W-1:0] a_4_data;
    logic [DATA_W-1:0] a_5_data;
    logic [DATA_W-1:0] a_6_data;
    logic [DATA_W-1:0] a_7_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        out_idx;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        input  start, a_0_data, a_1_data, a_2_data, a_3_data,
               a_4_data, a_5_data, a_6_data, a_7_data, out_ready,
        output out_valid, out_data, out_idx, out_last, busy, done
    );

    modport slave (
        output start, a_0_data, a_1_data, a_2_data, a_3_data,
               a_4_data, a_5_data, a_6_data, a_7_data, out_ready,
        input  out_valid, out_data, out_idx, out_last, busy, done
    );
endinterface

// File: rtl/vector_a_stream_reader.sv
// Streams the eight vector-A entries out one per valid/ready transfer, in index order.
// Optional macro VEC_A_RD_SKIP_ZERO_EN: skip entries that are zero at the start edge.
module vector_a_stream_reader #(
    parameter int DATA_W   = 34,
    parameter bit SNAPSHOT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    vector_a_stream_reader_if.master bus
);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] liveVec [8];
    logic [DATA_W-1:0] snap_q  [8];
    logic [7:0]        mask_q;
    logic [7:0]        startMask_d;
    logic [2:0]        idx_q;
    logic              valid_q;
    logic              last_q;
    logic              busy_q;
    logic              done_q;
    logic [3:0]        firstHit_d;
    logic [3:0]        afterFirst_d;
    logic [3:0]        nextHit_d;
    logic [3:0]        afterNext_d;

    // Returns {found, index} of the lowest set mask bit at or above 'from'.
    function automatic logic [3:0] firstSetFrom(input logic [7:0] m, input int from);
        logic [3:0] r;
        r = 4'b0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (i >= from)) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    assign liveVec[0] = bus.a_0_data;
    assign liveVec[1] = bus.a_1_data;
    assign liveVec[2] = bus.a_2_data;
    assign liveVec[3] = bus.a_3_data;
    assign liveVec[4] = bus.a_4_data;
    assign liveVec[5] = bus.a_5_data;
    assign liveVec[6] = bus.a_6_data;
    assign liveVec[7] = bus.a_7_data;

    always_comb begin
        startMask_d = 8'hFF;
`ifdef VEC_A_RD_SKIP_ZERO_EN
        for (int i = 0; i < 8; i++) startMask_d[i] = |liveVec[i];
`endif
    end

    // out_last for an index is simply "no set mask bit above it".
    always_comb begin
        firstHit_d   = firstSetFrom(mask_q, 0);
        afterFirst_d = firstSetFrom(mask_q, int'(firstHit_d[2:0]) + 1);
        nextHit_d    = firstSetFrom(mask_q, int'(idx_q) + 1);
        afterNext_d  = firstSetFrom(mask_q, int'(nextHit_d[2:0]) + 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= 8'h00;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 8; i++) snap_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (SNAPSHOT) begin
                            for (int i = 0; i < 8; i++) snap_q[i] <= liveVec[i];
                        end
                        mask_q  <= startMask_d;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (firstHit_d[3]) begin
                        idx_q   <= firstHit_d[2:0];
                        last_q  <= !afterFirst_d[3];
                        valid_q <= 1'b1;
                        state_q <= STREAM;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                STREAM: begin
                    if (valid_q && bus.out_ready) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            idx_q  <= nextHit_d[2:0];
                            last_q <= !afterNext_d[3];
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    idx_q   <= 3'd0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Data and index read as zero whenever nothing is being offered.
    assign bus.out_valid = valid_q;
    assign bus.out_data  = valid_q ? (SNAPSHOT ? snap_q[idx_q] : liveVec[idx_q]) : '0;
    assign bus.out_idx   = valid_q ? idx_q : 3'd0;
    assign bus.out_last  = last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_vector_a_stream_reader.sv
// Directed self-checking bench for vector_a_stream_reader (default SNAPSHOT=1 build).
// The zero-skip scenarios are selected when VEC_A_RD_SKIP_ZERO_EN is defined.
module tb_vector_a_stream_reader;

    logic        clk;
    logic        rst;
    logic [33:0] aVec    [8];
    logic [33:0] expData [8];
    logic [2:0]  expIdx  [8];
    int          testsRun;
    int          testsFailed;

    vector_a_stream_reader_if #(.DATA_W(34)) bus ();

    vector_a_stream_reader #(.DATA_W(34), .SNAPSHOT(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.a_0_data = aVec[0];
    assign bus.a_1_data = aVec[1];
    assign bus.a_2_data = aVec[2];
    assign bus.a_3_data = aVec[3];
    assign bus.a_4_data = aVec[4];
    assign bus.a_5_data = aVec[5];
    assign bus.a_6_data = aVec[6];
    assign bus.a_7_data = aVec[7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Runs one sequence already started; cycle c counts cycles after the start edge.
    task automatic streamRun(input string tag, input int readyMode, input int expCount,
                             input bit midAction);
        int          n = 0;
        int          doneCount = 0;
        int          lastXfer = -1;
        int          firstValid = -1;
        bit          finished = 0;
        bit          didMid = 0;
        logic        prevHold = 0;
        logic [33:0] prevD = '0;
        logic [2:0]  prevI = '0;
        logic        prevL = 0;
        checkOutput({tag, "_loadValid"}, 64'(bus.out_valid), 64'd0);
        checkOutput({tag, "_loadBusy"}, 64'(bus.busy), 64'd1);
        for (int c = 1; c <= 60 && !finished; c++) begin
            bus.out_ready = (readyMode == 1) ? (c % 2 == 0) : 1'b1;
            bus.start = 1'b0;
            if (midAction && n == 2 && !didMid) begin
                aVec[3]   = 34'h3FFFFFFFF;
                bus.start = 1'b1;
                didMid    = 1;
            end
            #0;
            if (bus.out_valid) begin
                if (firstValid < 0) firstValid = c;
                if (prevHold) begin
                    checkOutput($sformatf("%s_holdData%0d", tag, n), 64'(bus.out_data), 64'(prevD));
                    checkOutput($sformatf("%s_holdIdx%0d", tag, n), 64'(bus.out_idx), 64'(prevI));
                    checkOutput($sformatf("%s_holdLast%0d", tag, n), 64'(bus.out_last), 64'(prevL));
                end
                if (bus.out_ready) begin
                    if (n < expCount) begin
                        checkOutput($sformatf("%s_data%0d", tag, n), 64'(bus.out_data), 64'(expData[n]));
                        checkOutput($sformatf("%s_idx%0d", tag, n), 64'(bus.out_idx), 64'(expIdx[n]));
                        checkOutput($sformatf("%s_last%0d", tag, n), 64'(bus.out_last),
                                    64'(n == expCount - 1));
                    end
                    n++;
                    lastXfer = c;
                end
            end
            prevHold = bus.out_valid && !bus.out_ready;
            prevD = bus.out_data;
            prevI = bus.out_idx;
            prevL = bus.out_last;
            if (doneCount > 0 && !bus.done) begin
                checkOutput({tag, "_idleBusy"}, 64'(bus.busy), 64'd0);
                finished = 1;
            end
            if (bus.done) begin
                doneCount++;
                checkOutput({tag, "_doneCycle"}, 64'(c), (expCount == 0) ? 64'd2 : 64'(lastXfer + 1));
                checkOutput({tag, "_doneValid"}, 64'(bus.out_valid), 64'd0);
                checkOutput({tag, "_doneBusy"}, 64'(bus.busy), 64'd1);
            end
            if (!finished) tick();
        end
        bus.start = 1'b0;
        checkOutput({tag, "_xferCount"}, 64'(n), 64'(expCount));
        checkOutput({tag, "_doneCount"}, 64'(doneCount), 64'd1);
        checkOutput({tag, "_firstValid"}, 64'(firstValid), (expCount == 0) ? -64'sd1 : 64'd2);
    endtask

    initial begin
        int n;
        testsRun    = 0;
        testsFailed = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) aVec[i] = '0;
        repeat (3) tick();
        checkOutput("rstValid", 64'(bus.out_valid), 64'd0);
        checkOutput("rstData", 64'(bus.out_data), 64'd0);
        checkOutput("rstIdx", 64'(bus.out_idx), 64'd0);
        checkOutput("rstLast", 64'(bus.out_last), 64'd0);
        checkOutput("rstBusy", 64'(bus.busy), 64'd0);
        checkOutput("rstDone", 64'(bus.done), 64'd0);
        rst = 1'b0;
        tick();

        // Basic stream, ready always high.
        for (int i = 0; i < 8; i++) begin
            aVec[i]    = 34'(i + 1);
            expData[i] = 34'(i + 1);
            expIdx[i]  = 3'(i);
        end
        applyStimulus();
        streamRun("t1", 0, 8, 0);
        tick();

        // Ready toggling every cycle.
        applyStimulus();
        streamRun("t2", 1, 8, 0);
        tick();

        // Overwrite a_3 and pulse start mid-stream; snapshot keeps old value.
        applyStimulus();
        streamRun("t3", 0, 8, 1);
        aVec[3] = 34'd4;
        tick();

        // Async reset after the third transfer.
        applyStimulus();
        bus.out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 30 && n < 3; c++) begin
            if (bus.out_valid) n++;
            tick();
        end
        checkOutput("t4_preRstXfers", 64'(n), 64'd3);
        rst = 1'b1;
        #1;
        checkOutput("t4_rstValid", 64'(bus.out_valid), 64'd0);
        checkOutput("t4_rstData", 64'(bus.out_data), 64'd0);
        checkOutput("t4_rstIdx", 64'(bus.out_idx), 64'd0);
        checkOutput("t4_rstBusy", 64'(bus.busy), 64'd0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("t4_noDone%0d", c), 64'(bus.done), 64'd0);
        end
        applyStimulus();
        streamRun("t4", 0, 8, 0);
        tick();

`ifdef VEC_A_RD_SKIP_ZERO_EN
        for (int i = 0; i < 8; i++) aVec[i] = '0;
        aVec[1] = 34'h200000001;
        aVec[4] = 34'h5;
        aVec[7] = 34'h3FFFFFFFF;
        expData[0] = 34'h200000001; expIdx[0] = 3'd1;
        expData[1] = 34'h5;         expIdx[1] = 3'd4;
        expData[2] = 34'h3FFFFFFFF; expIdx[2] = 3'd7;
        applyStimulus();
        streamRun("t5sparse", 0, 3, 0);
        tick();
        aVec[1] = '0;
        aVec[4] = '0;
        aVec[7] = '0;
        applyStimulus();
        streamRun("t5zero", 0, 0, 0);
        tick();
`else
        for (int i = 0; i < 8; i++) begin
            aVec[i]    = '0;
            expData[i] = '0;
            expIdx[i]  = 3'(i);
        end
        applyStimulus();
        streamRun("t6", 0, 8, 0);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
